// File: rtl/learn_pkg.sv
// Shared constants, packet byte layout and FSM encoding for the packet fetch / learnCosts path.
package learn_pkg;

    localparam int MEM_DEPTH  = 1024;
    localparam int MEM_WIDTH  = 8;
    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 10;
    localparam int PKT_BYTES  = 8;
    localparam int IDX_WIDTH  = 4;

    // Byte offset of each field's high byte; the low byte follows it (big-endian).
    localparam logic [2:0] SRC_OFS = 3'd0;
    localparam logic [2:0] BAT_OFS = 3'd2;
    localparam logic [2:0] VAL_OFS = 3'd4;
    localparam logic [2:0] CLU_OFS = 3'd6;

    localparam logic [IDX_WIDTH-1:0] LAST_DATA_IDX = IDX_WIDTH'(PKT_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_HANDOFF   = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FINISH    = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/pkt_field_assembler.sv
// Collects packet bytes by index and presents them as four big-endian 16-bit fields.
module pkt_field_assembler
    import learn_pkg::*;
(
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  wrEn_i,
    input  logic [IDX_WIDTH-1:0]  byteIdx_i,
    input  logic [MEM_WIDTH-1:0]  byteData_i,
    output logic [WORD_WIDTH-1:0] sourceId_o,
    output logic [WORD_WIDTH-1:0] batteryStat_o,
    output logic [WORD_WIDTH-1:0] value_o,
    output logic [WORD_WIDTH-1:0] clusterId_o
);

    logic [MEM_WIDTH-1:0] bytes_q [0:PKT_BYTES-1];

    // Indices past the data bytes (the optional checksum byte) never touch the fields.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < PKT_BYTES; i++) begin
                bytes_q[i] <= '0;
            end
        end else if (wrEn_i && (byteIdx_i <= LAST_DATA_IDX)) begin
            bytes_q[byteIdx_i[2:0]] <= byteData_i;
        end
    end

    assign sourceId_o    = {bytes_q[SRC_OFS], bytes_q[SRC_OFS + 3'd1]};
    assign batteryStat_o = {bytes_q[BAT_OFS], bytes_q[BAT_OFS + 3'd1]};
    assign value_o       = {bytes_q[VAL_OFS], bytes_q[VAL_OFS + 3'd1]};
    assign clusterId_o   = {bytes_q[CLU_OFS], bytes_q[CLU_OFS + 3'd1]};

endmodule

// File: rtl/fetch_packet.sv
// Reads one packet from packet memory, hands its fields to learnCosts and waits for completion.
// Optional FETCH_CHECKSUM_EN: reads a ninth XOR checksum byte and adds the pkt_err output.
module fetch_packet
    import learn_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_fetch,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_ren,
    input  logic [MEM_WIDTH-1:0]  mem_rdata,
    output logic [WORD_WIDTH-1:0] fsourceID,
    output logic [WORD_WIDTH-1:0] fbatteryStat,
    output logic [WORD_WIDTH-1:0] fValue,
    output logic [WORD_WIDTH-1:0] fclusterID,
    output logic                  start_learnCosts,
    input  logic                  done_learnCosts,
    output logic                  busy,
    output logic                  done_fetch
`ifdef FETCH_CHECKSUM_EN
    ,
    output logic                  pkt_err
`endif
);

`ifdef FETCH_CHECKSUM_EN
    localparam logic [IDX_WIDTH-1:0] LAST_READ_IDX = IDX_WIDTH'(PKT_BYTES);
`else
    localparam logic [IDX_WIDTH-1:0] LAST_READ_IDX = IDX_WIDTH'(PKT_BYTES - 1);
`endif

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] memAddr_q;
    logic [IDX_WIDTH-1:0]  rdIdx_q;
    logic                  capValid_q;
    logic [IDX_WIDTH-1:0]  capIdx_q;
    logic                  chkBad;
    logic                  startAccepted;

    assign startAccepted = (state_q == ST_IDLE) && start_fetch;
    assign mem_addr      = memAddr_q;

`ifdef FETCH_CHECKSUM_EN
    logic [MEM_WIDTH-1:0] chkAcc_q;
    logic                 errFlag_q;

    // Running XOR of the data bytes; the checksum byte arrives during DRAIN.
    always_ff @(posedge clock) begin
        if (reset) begin
            chkAcc_q  <= '0;
            errFlag_q <= 1'b0;
        end else if (startAccepted) begin
            chkAcc_q  <= '0;
            errFlag_q <= 1'b0;
        end else begin
            if (capValid_q && (capIdx_q <= LAST_DATA_IDX)) begin
                chkAcc_q <= chkAcc_q ^ mem_rdata;
            end
            if ((state_q == ST_DRAIN) && chkBad) begin
                errFlag_q <= 1'b1;
            end
        end
    end

    assign chkBad  = capValid_q && (capIdx_q == LAST_READ_IDX) && (mem_rdata != chkAcc_q);
    assign pkt_err = (state_q == ST_FINISH) && errFlag_q;
`else
    assign chkBad = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            memAddr_q  <= '0;
            rdIdx_q    <= '0;
            capValid_q <= 1'b0;
            capIdx_q   <= '0;
        end else begin
            state_q    <= state_d;
            capValid_q <= mem_ren;
            capIdx_q   <= rdIdx_q;
            // The address stops advancing on the last read so it holds once mem_ren drops.
            if (startAccepted) begin
                memAddr_q <= base_addr;
                rdIdx_q   <= '0;
            end else if (mem_ren && (rdIdx_q != LAST_READ_IDX)) begin
                memAddr_q <= memAddr_q + ADDR_WIDTH'(1);
                rdIdx_q   <= rdIdx_q + IDX_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        mem_ren          = 1'b0;
        start_learnCosts = 1'b0;
        done_fetch       = 1'b0;
        busy             = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_fetch) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                mem_ren = 1'b1;
                if (rdIdx_q == LAST_READ_IDX) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = chkBad ? ST_FINISH : ST_HANDOFF;
            end
            ST_HANDOFF: begin
                start_learnCosts = 1'b1;
                state_d          = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_learnCosts) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_fetch = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    pkt_field_assembler uAssembler (
        .clock_i       (clock),
        .reset_i       (reset),
        .wrEn_i        (capValid_q),
        .byteIdx_i     (capIdx_q),
        .byteData_i    (mem_rdata),
        .sourceId_o    (fsourceID),
        .batteryStat_o (fbatteryStat),
        .value_o       (fValue),
        .clusterId_o   (fclusterID)
    );

endmodule

// File: doc/fetch_packet.md
FETCH_PACKET -- requirements
Module: fetch_packet

Interface
REQ-001 SHALL have: clock  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: start_fetch  input  1  one-cycle request to fetch a packet; honoured only in IDLE.
REQ-004 SHALL have: base_addr  input  10  byte address of the packet's first byte; sampled with start_fetch.
REQ-005 SHALL have: mem_addr  output  10  packet-memory read address (1024 x 8 memory).
REQ-006 SHALL have: mem_ren  output  1  read enable; mem_rdata is valid exactly one cycle after each mem_ren cycle.
REQ-007 SHALL have: mem_rdata  input  8  read data from packet memory.
REQ-008 SHALL have: fsourceID, fbatteryStat, fValue, fclusterID  output  16 each  assembled packet fields for the learnCosts stage.
REQ-009 SHALL have: start_learnCosts  output  1  one-cycle pulse telling learnCosts the fields are valid.
REQ-010 SHALL have: done_learnCosts  input  1  completion from learnCosts; level or pulse accepted.
REQ-011 SHALL have: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have: done_fetch  output  1  one-cycle pulse when the packet has been fully processed.

Function
REQ-013 SHALL use the packet layout: bytes 0-7 = sourceID, batteryStat, Value, clusterID, each big-endian (high byte first).
REQ-014 SHALL implement states IDLE -> READ -> DRAIN -> HANDOFF -> WAIT_DONE -> FINISH -> IDLE.
REQ-015 IDLE: on start_fetch=1 SHALL latch base_addr and go to READ next cycle; start_fetch outside IDLE SHALL be ignored.
REQ-016 READ: SHALL assert mem_ren for exactly 8 consecutive cycles with mem_addr = base_addr+0 .. base_addr+7.
REQ-017 Address arithmetic SHALL be modulo 1024 (e.g. base 0x3FE reads 0x3FE, 0x3FF, 0x000 .. 0x005).
REQ-018 Each returned byte SHALL be written into its field byte position in the cycle it arrives; DRAIN lasts one cycle to capture the last byte.
REQ-019 HANDOFF: start_learnCosts SHALL be high for exactly one cycle; 10 cycles after the start_fetch cycle; fields stable from then until the next accepted start_fetch.
REQ-020 WAIT_DONE: SHALL hold until done_learnCosts=1; done_learnCosts in any other state SHALL be ignored.
REQ-021 FINISH: done_fetch SHALL pulse one cycle, the cycle after done_learnCosts is seen; return to IDLE next cycle.
REQ-022 mem_ren SHALL be 0 outside READ; mem_addr SHALL hold its last value when mem_ren=0.

Reset
REQ-023 reset=1 at a rising edge SHALL force IDLE, with mem_ren, start_learnCosts, done_fetch, busy = 0, mem_addr = 0, all four fields = 0x0000.
REQ-024 reset SHALL override start_fetch in the same cycle; reset mid-READ or WAIT_DONE SHALL abort with no start_learnCosts or done_fetch pulse.

Configuration
REQ-025 Macro FETCH_CHECKSUM_EN defined: READ SHALL issue 9 reads; byte 8 is the XOR of bytes 0-7; output pkt_err (1 bit) added.
REQ-026 With FETCH_CHECKSUM_EN, mismatch SHALL skip HANDOFF/WAIT_DONE, pulse pkt_err and done_fetch together for one cycle, then return to IDLE; pkt_err resets to 0.
REQ-027 Without FETCH_CHECKSUM_EN: no pkt_err port, 8 reads, timing per REQ-019.

Structure
REQ-028 Shared package learn_pkg SHALL hold MEM_DEPTH=1024, MEM_WIDTH=8, WORD_WIDTH=16, ADDR_WIDTH=10, PKT_BYTES=8, field byte offsets and the state encoding.
REQ-029 Byte-to-word assembly SHALL be a sub-module pkt_field_assembler (byte index + data in, four 16-bit fields out).

Verification
REQ-030 Nominal: base 0x010, bytes 12 34 00 64 01 F4 00 07 -> fields 0x1234/0x0064/0x01F4/0x0007, start_learnCosts at cycle 10.
REQ-031 Wrap: base 0x3FC -> mem_addr sequence 0x3FC..0x3FF, 0x000..0x003.
REQ-032 Handshake: done_learnCosts held 0 for 50 cycles then 1 -> busy stays 1, done_fetch pulses once, one cycle later.
REQ-033 Reset at cycle 5 of READ -> outputs per REQ-023 next cycle; no start_learnCosts; fresh start_fetch works.
REQ-034 start_fetch re-asserted during WAIT_DONE -> ignored; fields unchanged.
REQ-035 FETCH_CHECKSUM_EN, bad byte 8 -> pkt_err and done_fetch pulse, no start_learnCosts.
